// File: rtl/picorv32_mem_pkg.sv
// Shared types for the picorv32 native memory arbiter: FSM states, master index
// and the packed native-memory request bundle.
package picorv32_mem_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef logic mst_idx_t;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

endpackage

// File: rtl/picorv32_mem_watchdog.sv
// Slave wait-time watchdog: counts BUSY cycles without mem_ready and flags the
// cycle where the count reaches MAX_WAIT-1 while the slave is still silent.
module picorv32_mem_watchdog #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_busy,
  input  logic i_mem_ready,
  output logic o_timeout
);

  localparam int unsigned CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT - 1);

  logic [CW-1:0] r_cnt;

  // Every BUSY period is preceded by at least one IDLE cycle, so clearing
  // while idle is the same as clearing on entry to BUSY.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_busy) begin
      r_cnt <= '0;
    end else if (!i_mem_ready) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_timeout = i_busy & ~i_mem_ready & (r_cnt == LIMIT);

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Round-robin two-master arbiter for the picorv32 native memory interface.
// Optional slave watchdog enabled by defining PICORV32_MEM_ARBITER_WATCHDOG_EN.
module picorv32_mem_arbiter
  import picorv32_mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        owner,
  output logic        timeout
);

  arb_state_e r_state, w_state_nxt;
  mst_idx_t   r_owner, w_owner_nxt;
  mst_idx_t   r_last,  w_last_nxt;
  mem_req_t   w_req0, w_req1, w_req_own;
  logic       w_busy, w_timeout, w_done;

  assign w_req0 = '{valid: m0_valid, instr: m0_instr, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign w_req1 = '{valid: m1_valid, instr: m1_instr, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
  assign w_req_own = r_owner ? w_req1 : w_req0;
  assign w_busy    = (r_state == ARB_BUSY);
  assign w_done    = w_busy & (mem_ready | w_timeout);

`ifdef PICORV32_MEM_ARBITER_WATCHDOG_EN
  picorv32_mem_watchdog #(
    .MAX_WAIT(MAX_WAIT)
  ) u_watchdog (
    .i_clk      (clk),
    .i_rst_n    (resetn),
    .i_busy     (w_busy),
    .i_mem_ready(mem_ready),
    .o_timeout  (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ARB_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    unique case (r_state)
      ARB_IDLE: begin
        if (m0_valid && m1_valid) begin
          w_state_nxt = ARB_BUSY;
          w_owner_nxt = ~r_last;
        end else if (m0_valid) begin
          w_state_nxt = ARB_BUSY;
          w_owner_nxt = 1'b0;
        end else if (m1_valid) begin
          w_state_nxt = ARB_BUSY;
          w_owner_nxt = 1'b1;
        end
      end
      ARB_BUSY: begin
        // Completion (slave or watchdog) wins over an owner abort.
        if (w_done) begin
          w_state_nxt = ARB_IDLE;
          w_last_nxt  = r_owner;
        end else if (!w_req_own.valid) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    m0_ready  = 1'b0;
    m0_rdata  = '0;
    m1_ready  = 1'b0;
    m1_rdata  = '0;
    if (w_busy) begin
      mem_valid = w_req_own.valid & ~w_timeout;
      mem_instr = w_req_own.instr;
      mem_addr  = w_req_own.addr;
      mem_wdata = w_req_own.wdata;
      mem_wstrb = w_req_own.wstrb;
      if (r_owner) begin
        m1_ready = mem_ready | w_timeout;
        m1_rdata = w_timeout ? '0 : mem_rdata;
      end else begin
        m0_ready = mem_ready | w_timeout;
        m0_rdata = w_timeout ? '0 : mem_rdata;
      end
    end
  end

  assign busy    = w_busy;
  assign owner   = r_owner;
  assign timeout = w_timeout;

endmodule

// File: doc/picorv32_mem_arbiter.md
# picorv32_mem_arbiter

Two-master arbiter that shares one picorv32 native memory port (valid/ready, addr, wdata, wstrb, rdata, instr) between two requesters, e.g. a picorv32 core and a second core or DMA engine. It sits between the masters and the single memory or bus-model port used by the formal and simulation benches. Arbitration is round-robin with ownership held until the slave completes the transfer. An optional watchdog bounds slave wait time.

## Interface
- MAX_WAIT, 16: watchdog limit in BUSY cycles without mem_ready; must be ≥ 2. Ignored when the watchdog is compiled out.
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- m0_valid, m1_valid  in  1  master request, held until its ready
- m0_instr, m1_instr  in  1  instruction-fetch flag
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  write data
- m0_wstrb, m1_wstrb  in  4  byte write strobes; 0 means read
- m0_ready, m1_ready  out  1  transfer complete to that master
- m0_rdata, m1_rdata  out  32  read data
- mem_valid  out  1  slave request
- mem_instr  out  1  muxed instr flag
- mem_addr  out  32  muxed address
- mem_wdata  out  32  muxed write data
- mem_wstrb  out  4  muxed strobes
- mem_ready  in  1  slave completion
- mem_rdata  in  32  slave read data
- busy  out  1  a master currently owns the port
- owner  out  1  index of the owning master; valid only while busy
- timeout  out  1  one-cycle pulse when the watchdog aborts a transfer

## Operation
- State machine has two states, IDLE and BUSY. Registers: state, owner, last (index of the most recently served master).
- In IDLE with exactly one mX_valid: next state BUSY, owner = X.
- In IDLE with both valid: owner = !last, which alternates service.
- In IDLE with no valid: stay in IDLE.
- In BUSY:
  - mem_* request outputs are a combinational mux of the owner's signals.
  - mem_valid = owner's valid.
  - Owner's ready = mem_ready and owner's rdata = mem_rdata.
  - The non-owner sees ready = 0 and rdata = 0.
- In BUSY with mem_ready: next state IDLE, last = owner.
- In BUSY with the owner's valid deasserted (protocol violation, abort): next state IDLE, last unchanged. No ready is returned.
- In IDLE:
  - mem_valid = 0 and both mX_ready = 0.
  - mem_addr, mem_wdata, mem_wstrb and mem_instr = 0.
- A non-owner request waiting in BUSY is held, never dropped. It wins the next IDLE cycle if the other master does not re-request, or by round-robin if both request.
- Reset values: state IDLE, owner 0, last 1 (m0 wins the first tie), busy 0, timeout 0. All mem_* outputs and mX_ready are 0.
- Reset asserted mid-transfer: the arbiter enters IDLE immediately, without waiting for mem_ready.

## Timing
- Request sampled in IDLE at cycle T → busy and mem_valid asserted at T+1.
- mem_ready at cycle R → mX_ready in the same cycle R (combinational, zero latency). IDLE at R+1.
- Every grant costs one IDLE bubble cycle. Back-to-back requests see mem_valid at R+2 at the earliest.
- Zero-wait slave (mem_ready in the same cycle mem_valid rises): a transfer completes in 2 cycles from request.
- No combinational path from mX_valid to mX_ready. There is a combinational path mem_ready → mX_ready.

## Configuration
- Macro: PICORV32_MEM_ARBITER_WATCHDOG_EN.
- Defined:
  - A wait counter is cleared on every entry to BUSY and increments each BUSY cycle without mem_ready.
  - On the cycle the counter equals MAX_WAIT-1 with mem_ready still low, the arbiter pulses timeout for one cycle.
  - In that same cycle it drives the owner's ready = 1 with rdata = 0 and forces mem_valid = 0.
  - It then returns to IDLE with last = owner.
  - mem_ready in that same cycle takes precedence: normal completion, no timeout.
- Undefined: no counter is present, timeout is tied to 0, and MAX_WAIT is unused.

## Structure
- Shared package picorv32_mem_pkg holds:
  - the arbiter state enum (ARB_IDLE, ARB_BUSY);
  - the master index typedef;
  - a packed native-memory request struct (valid, instr, addr, wdata, wstrb).
- One sub-module, picorv32_mem_watchdog: counter, compare against MAX_WAIT-1, timeout pulse. It is instantiated only under the macro.

## Test plan
- After reset, m0 read at addr 0x100, slave ready after 3 wait cycles returning 0xDEADBEEF → m0_ready at the 4th BUSY cycle, m0_rdata = 0xDEADBEEF, m1_ready stays 0.
- m0 and m1 both valid in the same cycle after reset → m0 served first; m1 is granted at the first IDLE cycle after m0's ready, with mem_addr equal to m1_addr.
- Both masters requesting continuously with zero-wait slave → owner alternates 0,1,0,1; mem_valid has a period of 2 cycles.
- m1 write (addr 0x200, wdata 0x12345678, wstrb 0xF) → mem_wstrb = 0xF and mem_wdata = 0x12345678 in BUSY. Deassert resetn mid-transfer → mem_valid = 0 and busy = 0 immediately.
- Watchdog build with MAX_WAIT = 4, mem_ready never asserted → timeout and m0_ready pulse in the 4th BUSY cycle with m0_rdata = 0, then IDLE.
- Watchdog build with mem_ready asserted exactly in the 4th BUSY cycle → normal completion with slave data, timeout stays 0.
